ex_issue_ctrl: RTL and testbench

Execute-stage sequencer that owns the ID/EX pipeline register feeding the ALU.
- Accepts one decoded instruction at a time from decode (valid/ready) and holds ALU operands stable while the op completes.
- Inserts wait cycles for the clocked shift/rotate path.
- Hands the result to the memory stage (valid/ready) and resolves branches/jumps into a one-cycle redirect to fetch/decode.

---
 rtl/ex_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: owns the ID/EX register, stalls for the clocked shift path,
// hands results to memory and pulses branch/jump redirects. Optional counters: EX_PERF_CNT_EN.
module ex_issue_ctrl #(
  parameter int unsigned SHIFT_LAT = 1,
  parameter int unsigned PERF_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [15:0] id_pc,
  input  logic [15:0] id_inst,
  input  logic [4:0]  id_opcode,
  input  logic [25:0] id_uop,
  input  logic [15:0] id_rs,
  input  logic [15:0] id_rt,
  input  logic [2:0]  id_dest,
  input  logic [6:0]  id_ctrl,
  output logic [15:0] alu_pc,
  output logic [15:0] alu_inst,
  output logic [15:0] alu_rs,
  output logic [15:0] alu_rt,
  output logic [4:0]  alu_opcode,
  output logic [25:0] alu_uop,
  output logic [6:0]  alu_ctrl,
  output logic [2:0]  alu_dest,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_pc_nxt,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [15:0] mem_data,
  output logic [15:0] mem_st_data,
  output logic [2:0]  mem_dest,
  output logic        mem_wr_en,
  output logic        mem_ldst,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic [1:0]  dbg_state
`ifdef EX_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_redirect
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] SHIFT_CNT = 3'(SHIFT_LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       taken;
  logic       handshake;
  logic       accept;
  logic       is_shift;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high; valid never
  // depends on ready, and the sender holds its payload stable while valid is high and ready low.
  assign handshake = (state == DONE) & mem_ready;
  assign taken     = (state == DONE) &
                     (alu_ctrl[2] | alu_ctrl[4] | (alu_ctrl[3] & alu_result[0]));
  assign id_ready  = (state == EMPTY) | (handshake & ~taken);
  assign accept    = id_valid & id_ready;
  assign is_shift  = id_uop[20] | id_uop[24];

  assign mem_valid      = (state == DONE);
  assign mem_data       = alu_result;
  assign mem_st_data    = alu_rt;
  assign mem_dest       = alu_dest;
  assign mem_wr_en      = alu_ctrl[6];
  assign mem_ldst       = alu_ctrl[1];
  assign redirect_valid = handshake & taken;
  assign redirect_pc    = alu_pc_nxt;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      cnt        <= 3'd0;
      alu_pc     <= 16'd0;
      alu_inst   <= 16'd0;
      alu_rs     <= 16'd0;
      alu_rt     <= 16'd0;
      alu_opcode <= 5'd0;
      alu_uop    <= 26'd0;
      alu_ctrl   <= 7'd0;
      alu_dest   <= 3'd0;
    end else if (accept) begin
      alu_pc     <= id_pc;
      alu_inst   <= id_inst;
      alu_rs     <= id_rs;
      alu_rt     <= id_rt;
      alu_opcode <= id_opcode;
      alu_uop    <= id_uop;
      alu_ctrl   <= id_ctrl;
      alu_dest   <= id_dest;
      if (is_shift && (SHIFT_LAT != 0)) begin
        state <= WAIT;
        cnt   <= SHIFT_CNT;
      end else begin
        state <= DONE;
      end
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= DONE;
        end
        DONE: begin
          // Leaving DONE without a new op: zero ctrl/uop so the ALU sees no valid operation.
          if (mem_ready) begin
            state    <= EMPTY;
            alu_ctrl <= 7'd0;
            alu_uop  <= 26'd0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef EX_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired  <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      if (handshake && perf_retired != PERF_MAX)
        perf_retired <= perf_retired + PERF_ONE;
      if (((state == WAIT) || ((state == DONE) && !mem_ready)) && perf_stall != PERF_MAX)
        perf_stall <= perf_stall + PERF_ONE;
      if (redirect_valid && perf_redirect != PERF_MAX)
        perf_redirect <= perf_redirect + PERF_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl (SHIFT_LAT=1): hand-computed expectations plus a
// store-data scoreboard popped on every memory-stage handshake.
module tb_ex_issue_ctrl;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_pc, id_inst, id_rs, id_rt;
  logic [4:0]  id_opcode;
  logic [25:0] id_uop;
  logic [2:0]  id_dest;
  logic [6:0]  id_ctrl;
  logic [15:0] alu_pc, alu_inst, alu_rs, alu_rt;
  logic [4:0]  alu_opcode;
  logic [25:0] alu_uop;
  logic [6:0]  alu_ctrl;
  logic [2:0]  alu_dest;
  logic [15:0] alu_result, alu_pc_nxt;
  logic        mem_valid, mem_ready;
  logic [15:0] mem_data, mem_st_data;
  logic [2:0]  mem_dest;
  logic        mem_wr_en, mem_ldst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  dbg_state;
`ifdef EX_PERF_CNT_EN
  logic [15:0] perf_retired, perf_stall, perf_redirect;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  ex_issue_ctrl #(.SHIFT_LAT(1), .PERF_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_opcode(id_opcode), .id_uop(id_uop),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_ctrl(id_ctrl),
    .alu_pc(alu_pc), .alu_inst(alu_inst), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_opcode(alu_opcode), .alu_uop(alu_uop), .alu_ctrl(alu_ctrl), .alu_dest(alu_dest),
    .alu_result(alu_result), .alu_pc_nxt(alu_pc_nxt),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .mem_st_data(mem_st_data), .mem_dest(mem_dest), .mem_wr_en(mem_wr_en),
    .mem_ldst(mem_ldst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_state(dbg_state)
`ifdef EX_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_redirect(perf_redirect)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [15:0] pc, input logic [4:0] opc, input int ubit,
                          input logic [15:0] rs, input logic [15:0] rt,
                          input logic [2:0] dest, input logic [6:0] ctrl);
    id_valid  = 1'b1;
    id_pc     = pc;
    id_inst   = pc ^ 16'h5a5a;
    id_opcode = opc;
    id_uop    = 26'd1 << ubit;
    id_rs     = rs;
    id_rt     = rt;
    id_dest   = dest;
    id_ctrl   = ctrl;
  endtask

  task automatic idle_id();
    id_valid = 1'b0;
  endtask

  // Scoreboard: every memory handshake must carry the rt of the oldest accepted op.
  always @(negedge clk) begin
    if (rst && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("mem_st_data", mem_st_data, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; mem_ready = 1'b1; alu_result = 16'd0; alu_pc_nxt = 16'd0;
    id_pc = '0; id_inst = '0; id_opcode = '0; id_uop = '0; id_rs = '0; id_rt = '0;
    id_dest = '0; id_ctrl = '0;
    idle_id();
    tick(); tick();
    check("rst_state", dbg_state, S_EMPTY);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_redirect", redirect_valid, 1'b0);
    check("rst_id_ready", id_ready, 1'b1);
    check("rst_alu_ctrl", alu_ctrl, 7'd0);
    rst = 1'b1;
    tick();

    // Three back-to-back ADDs
    drive_id(16'h0100, 5'h01, 23, 16'h0001, 16'h00A1, 3'd1, 7'h41); exp_q.push_back(16'h00A1);
    #1 check("add_rdy0", id_ready, 1'b1);
    tick();
    drive_id(16'h0102, 5'h01, 23, 16'h0002, 16'h00B2, 3'd2, 7'h41); exp_q.push_back(16'h00B2);
    alu_result = 16'h1234;
    #1;
    check("add1_valid", mem_valid, 1'b1);
    check("add1_pc", alu_pc, 16'h0100);
    check("add1_uop", alu_uop, 26'h0800000);
    check("add1_data", mem_data, 16'h1234);
    check("add1_wr", mem_wr_en, 1'b1);
    check("add1_rdy", id_ready, 1'b1);
    tick();
    drive_id(16'h0104, 5'h01, 23, 16'h0003, 16'h00C3, 3'd3, 7'h41); exp_q.push_back(16'h00C3);
    alu_result = 16'h5678;
    #1;
    check("add2_valid", mem_valid, 1'b1);
    check("add2_pc", alu_pc, 16'h0102);
    check("add2_data", mem_data, 16'h5678);
    check("add2_rdy", id_ready, 1'b1);
    tick();
    idle_id(); alu_result = 16'h9abc;
    #1;
    check("add3_valid", mem_valid, 1'b1);
    check("add3_pc", alu_pc, 16'h0104);
    check("add3_dest", mem_dest, 3'd3);
    check("add3_rdy", id_ready, 1'b1);
    tick();
    check("add_empty", dbg_state, S_EMPTY);
    check("add_empty_valid", mem_valid, 1'b0);
    check("add_empty_ctrl", alu_ctrl, 7'd0);
    check("add_empty_uop", alu_uop, 26'd0);

    // SLLI with one wait cycle
    drive_id(16'h0200, 5'h14, 20, 16'h0004, 16'h00D4, 3'd4, 7'h41); exp_q.push_back(16'h00D4);
    tick();
    idle_id();
    check("sll_state", dbg_state, S_WAIT);
    check("sll_rdy", id_ready, 1'b0);
    check("sll_valid_w", mem_valid, 1'b0);
    tick();
    alu_result = 16'h0008;
    #1;
    check("sll_valid", mem_valid, 1'b1);
    check("sll_data", mem_data, 16'h0008);
    tick();
    check("sll_empty", dbg_state, S_EMPTY);

    // BEQZ taken, concurrent decode op must be refused
    drive_id(16'h0010, 5'h0C, 5, 16'h0000, 16'h00E5, 3'd0, 7'h09); exp_q.push_back(16'h00E5);
    tick();
    drive_id(16'h0012, 5'h01, 23, 16'h0000, 16'h0099, 3'd5, 7'h41);
    alu_result = 16'h0001; alu_pc_nxt = 16'h0016;
    #1;
    check("beqz_redir", redirect_valid, 1'b1);
    check("beqz_pc", redirect_pc, 16'h0016);
    check("beqz_rdy", id_ready, 1'b0);
    check("beqz_wr", mem_wr_en, 1'b0);
    tick();
    idle_id();
    check("beqz_redir_off", redirect_valid, 1'b0);
    check("beqz_empty", dbg_state, S_EMPTY);
    check("beqz_no_accept", mem_valid, 1'b0);

    // BNEZ not taken, next op accepted on the handshake, then 3 stalled cycles
    drive_id(16'h0020, 5'h0D, 6, 16'h0000, 16'h00F6, 3'd0, 7'h09); exp_q.push_back(16'h00F6);
    tick();
    drive_id(16'h0022, 5'h01, 23, 16'h0007, 16'h0017, 3'd6, 7'h41); exp_q.push_back(16'h0017);
    alu_result = 16'h0000; alu_pc_nxt = 16'h0040;
    #1;
    check("bnez_redir", redirect_valid, 1'b0);
    check("bnez_rdy", id_ready, 1'b1);
    tick();
    idle_id(); mem_ready = 1'b0; alu_result = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pc", alu_pc, 16'h0022);
      check("stall_valid", mem_valid, 1'b1);
      check("stall_st", mem_st_data, 16'h0017);
      check("stall_dest", mem_dest, 3'd6);
      check("stall_rdy", id_ready, 1'b0);
      check("stall_redir", redirect_valid, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("stall_done_rdy", id_ready, 1'b1);
    check("stall_done_data", mem_data, 16'h4321);
    tick();
    check("stall_empty", dbg_state, S_EMPTY);

    // JAL held one cycle, then link data and redirect together
    drive_id(16'h0030, 5'h10, 2, 16'h0000, 16'h00A8, 3'd7, 7'h45); exp_q.push_back(16'h00A8);
    tick();
    idle_id(); mem_ready = 1'b0; alu_result = 16'h0032; alu_pc_nxt = 16'h0100;
    #1;
    check("jal_hold_redir", redirect_valid, 1'b0);
    check("jal_hold_rdy", id_ready, 1'b0);
    tick();
    mem_ready = 1'b1;
    #1;
    check("jal_redir", redirect_valid, 1'b1);
    check("jal_pc", redirect_pc, 16'h0100);
    check("jal_link", mem_data, 16'h0032);
    check("jal_wr", mem_wr_en, 1'b1);
    tick();
    check("jal_redir_off", redirect_valid, 1'b0);
    check("jal_empty", dbg_state, S_EMPTY);

    // Reset while waiting on a shift drops the op
    drive_id(16'h0300, 5'h15, 24, 16'h0005, 16'h0055, 3'd2, 7'h61);
    tick();
    idle_id();
    check("rw_state", dbg_state, S_WAIT);
    rst = 1'b0;
    tick();
    check("rw_empty", dbg_state, S_EMPTY);
    check("rw_valid", mem_valid, 1'b0);
    check("rw_redir", redirect_valid, 1'b0);
    check("rw_ctrl", alu_ctrl, 7'd0);
    check("rw_rdy", id_ready, 1'b1);
    rst = 1'b1;
    tick(); tick();
    check("rw_quiet", mem_valid, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
